// File: rtl/bit_4_divider.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Zero divisor completes immediately with saturated results and a flag.
module bit_4_divider (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     state_q;
   logic [2:0] count_q;
   logic [4:0] prem_q;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [7:0] shreg_q;
   logic [3:0] dsor_q;

   logic [4:0] prem_shift;
   logic [4:0] prem_next;
   logic       qbit;

   always_comb begin
      prem_shift = {prem_q[3:0], shreg_q[7]};
      qbit       = (prem_shift >= {1'b0, dsor_q});
      prem_next  = qbit ? (prem_shift - {1'b0, dsor_q}) : prem_shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= 3'd0;
         prem_q      <= 5'd0;
         shreg_q     <= 8'd0;
         dsor_q      <= 4'd0;
         quotient    <= 8'd0;
         remainder   <= 4'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  shreg_q <= dividend;
                  dsor_q  <= divisor;
                  count_q <= 3'd0;
                  prem_q  <= 5'd0;
                  if (divisor == 4'd0) begin
                     state_q     <= StDone;
                     done        <= 1'b1;
                     quotient    <= 8'hFF;
                     remainder   <= 4'hF;
                     div_by_zero <= 1'b1;
                  end else begin
                     state_q <= StRun;
                     busy    <= 1'b1;
                  end
               end
            end
            StRun: begin
               prem_q  <= prem_next;
               shreg_q <= {shreg_q[6:0], qbit};
               count_q <= count_q + 3'd1;
               if (count_q == 3'd7) begin
                  state_q     <= StDone;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= {shreg_q[6:0], qbit};
                  remainder   <= prem_next[3:0];
                  div_by_zero <= 1'b0;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
   done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_bit_4_divider.sv
// Self-checking bench for bit_4_divider: directed table, corner sequences,
// randomized and exhaustive operations against an arithmetic reference model.
module tb_bit_4_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   bit_4_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned dvd;
      int unsigned dsr;
      int unsigned q;
      int unsigned r;
      int unsigned z;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned want);
      n_cmp++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, want);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, " quotient"}, quotient, 0);
      check({name, " remainder"}, remainder, 0);
      check({name, " busy"}, busy, 0);
      check({name, " done"}, done, 0);
      check({name, " div_by_zero"}, div_by_zero, 0);
   endtask

   // One complete operation from IDLE; pulse_run > 0 injects a 50/3 start in that RUN cycle,
   // pulse_done injects one during DONE. Returns with the DUT back in IDLE.
   task automatic do_op(input int unsigned a, input int unsigned b, input int unsigned eq,
                        input int unsigned er, input int unsigned ez, input int pulse_run,
                        input bit pulse_done, input string name);
      int cyc;
      int busy_cnt;
      int want_lat;
      start    = 1'b1;
      dividend = 8'(a);
      divisor  = 4'(b);
      tick();
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      cyc      = 1;
      busy_cnt = 0;
      while (!done && cyc <= 20) begin
         if (busy) busy_cnt++;
         if (pulse_run > 0 && cyc == pulse_run) begin
            start    = 1'b1;
            dividend = 8'd50;
            divisor  = 4'd3;
         end
         tick();
         start = 1'b0;
         cyc++;
      end
      want_lat = (b == 0) ? 1 : 9;
      check({name, " latency"}, cyc, want_lat);
      check({name, " busy cycles"}, busy_cnt, want_lat - 1);
      check({name, " quotient"}, quotient, eq);
      check({name, " remainder"}, remainder, er);
      check({name, " div_by_zero"}, div_by_zero, ez);
      check({name, " busy at done"}, busy, 0);
      if (pulse_done) begin
         start    = 1'b1;
         dividend = 8'd50;
         divisor  = 4'd3;
      end
      tick();
      start = 1'b0;
      check({name, " done one cycle"}, done, 0);
      check({name, " idle not busy"}, busy, 0);
      check({name, " quotient hold"}, quotient, eq);
      check({name, " remainder hold"}, remainder, er);
   endtask

   task automatic model_op(input int unsigned a, input int unsigned b, input string name);
      if (b == 0) do_op(a, b, 255, 15, 1, 0, 1'b0, name);
      else        do_op(a, b, a / b, a % b, 0, 0, 1'b0, name);
   endtask

   initial begin
      bit seen_done;
      vecs[0] = '{dvd: 200, dsr: 7,  q: 28,  r: 4,  z: 0};
      vecs[1] = '{dvd: 255, dsr: 1,  q: 255, r: 0,  z: 0};
      vecs[2] = '{dvd: 5,   dsr: 9,  q: 0,   r: 5,  z: 0};
      vecs[3] = '{dvd: 255, dsr: 15, q: 17,  r: 0,  z: 0};
      vecs[4] = '{dvd: 100, dsr: 0,  q: 255, r: 15, z: 1};
      vecs[5] = '{dvd: 0,   dsr: 5,  q: 0,   r: 0,  z: 0};
      vecs[6] = '{dvd: 14,  dsr: 14, q: 1,   r: 0,  z: 0};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 4'd0;
      #1;
      check_zero_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r, vecs[i].z, 0, 1'b0,
               $sformatf("vec%0d", i));
      end

      // Starts during RUN and DONE must be ignored; outputs must hold while idle.
      do_op(200, 7, 28, 4, 0, 4, 1'b1, "ignore_start");
      repeat (5) tick();
      check("hold busy", busy, 0);
      check("hold quotient", quotient, 28);
      check("hold remainder", remainder, 4);

      // Reset mid-RUN aborts immediately with no later done.
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("mid-run busy before reset", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async reset");
      @(negedge clk);
      rst_n     = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) seen_done = 1'b1;
      end
      check("no activity after abort", seen_done, 0);
      do_op(9, 2, 4, 1, 0, 0, 1'b0, "after_reset");

      for (int i = 0; i < 300; i++) begin
         model_op($urandom_range(0, 255), $urandom_range(0, 15), "rand");
      end

      for (int b = 1; b < 16; b++) begin
         for (int a = 0; a < 256; a++) begin
            model_op(a, b, $sformatf("sweep %0d/%0d", a, b));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
